// File: rtl/scan_config_loader.sv
// ============================================================================
//  Module      : scan_config_loader
//  Description : Host-to-scan-chain configuration loader. Serialises host words
//                LSB-first onto scan_in with single-cycle scan_clk pulses and
//                captures the chain's previous contents as readback words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module scan_config_loader #(
    parameter int CHAIN_LEN  = 29,
    parameter int WORD_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_data,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    output logic                  scan_clk,
    output logic                  scan_en,
    output logic                  scan_in,
    input  logic                  scan_out,
    output logic [WORD_WIDTH-1:0] rb_data,
    output logic                  rb_valid,
    output logic                  busy,
    output logic                  done
);

    localparam int                    c_WB_W     = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CNT_WIDTH-1:0]  c_LAST_BIT = CNT_WIDTH'(CHAIN_LEN - 1);
    localparam logic [c_WB_W-1:0]     c_LAST_WB  = c_WB_W'(WORD_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETUP  = 3'd2,
        S_PULSE  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t                r_state;
    logic [WORD_WIDTH-1:0] r_sreg;
    logic [WORD_WIDTH-1:0] r_rb_acc;
    logic [WORD_WIDTH-1:0] r_rb_data;
    logic [CNT_WIDTH-1:0]  r_bit_cnt;
    logic [c_WB_W-1:0]     r_word_bit;
    logic                  r_cfg_ready;
    logic                  r_scan_clk;
    logic                  r_scan_en;
    logic                  r_scan_in;
    logic                  r_rb_valid;
    logic                  r_busy;
    logic                  r_done;

    logic [WORD_WIDTH-1:0] w_sreg_next;
    logic                  w_last_bit;
    logic                  w_last_wb;

    assign w_sreg_next = r_sreg >> 1;
    assign w_last_bit  = (r_bit_cnt == c_LAST_BIT);
    assign w_last_wb   = (r_word_bit == c_LAST_WB);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sreg      <= '0;
            r_rb_acc    <= '0;
            r_rb_data   <= '0;
            r_bit_cnt   <= '0;
            r_word_bit  <= '0;
            r_cfg_ready <= 1'b0;
            r_scan_clk  <= 1'b0;
            r_scan_en   <= 1'b0;
            r_scan_in   <= 1'b0;
            r_rb_valid  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_LOAD;
                        r_done      <= 1'b0;
                        r_busy      <= 1'b1;
                        r_bit_cnt   <= '0;
                        r_cfg_ready <= 1'b1;
                        r_rb_acc    <= '0;
                    end
                end
                // scan_en is left untouched while waiting so a host stall
                // never disturbs the chain.
                S_LOAD: begin
                    if (cfg_valid && r_cfg_ready) begin
                        r_sreg      <= cfg_data;
                        r_word_bit  <= '0;
                        r_cfg_ready <= 1'b0;
                        r_scan_in   <= cfg_data[0];
                        r_scan_en   <= 1'b1;
                        r_scan_clk  <= 1'b0;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_rb_acc[r_word_bit] <= scan_out;
                    r_scan_clk           <= 1'b1;
                    r_state              <= S_PULSE;
                end
                S_PULSE: begin
                    r_sreg     <= w_sreg_next;
                    r_bit_cnt  <= r_bit_cnt + CNT_WIDTH'(1);
                    r_word_bit <= r_word_bit + c_WB_W'(1);
                    r_scan_clk <= 1'b0;
                    // Accumulator is cleared on publish so a final partial
                    // word comes out zero-padded.
                    if (w_last_bit || w_last_wb) begin
                        r_rb_data  <= r_rb_acc;
                        r_rb_valid <= 1'b1;
                        r_rb_acc   <= '0;
                    end
                    if (w_last_bit) begin
                        r_scan_en <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_FINISH;
                    end else if (w_last_wb) begin
                        r_cfg_ready <= 1'b1;
                        r_state     <= S_LOAD;
                    end else begin
                        r_scan_in <= w_sreg_next[0];
                        r_state   <= S_SETUP;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign scan_clk  = r_scan_clk;
    assign scan_en   = r_scan_en;
    assign scan_in   = r_scan_in;
    assign rb_data   = r_rb_data;
    assign rb_valid  = r_rb_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

`default_nettype wire
